// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle produced by vga_timing_gen and consumed by the
// scan-out stages. The generator drives every signal (master); consumers
// only observe them (slave). There is no back-pressure: the raster is
// free-running, so a consumer must act on each pix_ce_o cycle it sees.
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          pix_ce_o;
  logic          h_active;
  logic          v_active;
  logic          blank_n;
  logic          hs;
  logic          vs;
  logic [CW-1:0] x_o;
  logic [CW-1:0] y_o;
  logic          line_start_o;
  logic          frame_start_o;

  modport master (
    output pix_ce_o, h_active, v_active, blank_n, hs, vs,
           x_o, y_o, line_start_o, frame_start_o
  );

  modport slave (
    input  pix_ce_o, h_active, v_active, blank_n, hs, vs,
           x_o, y_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator with an integer pixel-clock
// prescaler. Counters sit at the idle position (H_TOTAL-1, V_TOTAL-1) while
// held in reset or disabled, so the first pixel enable always lands on (0,0)
// and produces a frame start. All decoded outputs are registered from the
// next-state position, so they change on the same edge as x_o/y_o.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int CW       = 12
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  vga_timing_gen_if.master    vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

  // Prescaler and raster position.
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          adv;

  // Registered decoded outputs.
  logic h_active_q, h_active_d;
  logic v_active_q, v_active_d;
  logic blank_n_q, blank_n_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Pixel enable is combinational so the consumer sees it in the same cycle
  // the counters will advance. It is gated by the reset input as well, so it
  // drops immediately when reset is asserted between edges.
  assign vga.pix_ce_o = en_i & rst_n_i & (div_q == DIV_LAST);

  // Next raster position: disable forces idle, otherwise step on the last
  // prescaler count, wrapping the line and then the frame.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    adv   = 1'b0;
    if (!en_i) begin
      div_d = '0;
      h_d   = H_LAST;
      v_d   = V_LAST;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      adv   = 1'b1;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Decode the next position so outputs stay aligned with x_o/y_o. The idle
  // position decodes to blanked, syncs inactive, which is also the reset
  // state. Strobes fire only on the advancing edge, so they last one clk_i.
  always_comb begin
    h_active_d    = (h_d < H_ACT_END);
    v_active_d    = (v_d < V_ACT_END);
    blank_n_d     = h_active_d & v_active_d;
    hs_d          = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vs_d          = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? VS_POL : ~VS_POL;
    line_start_d  = adv && (h_d == '0);
    frame_start_d = adv && (h_d == '0) && (v_d == '0);
  end

  // State and output registers with asynchronous active-low reset to idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q         <= '0;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      h_active_q    <= 1'b0;
      v_active_q    <= 1'b0;
      blank_n_q     <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      blank_n_q     <= blank_n_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.h_active      = h_active_q;
  assign vga.v_active      = v_active_q;
  assign vga.blank_n       = blank_n_q;
  assign vga.hs            = hs_q;
  assign vga.vs            = vs_q;
  assign vga.x_o           = h_q;
  assign vga.y_o           = v_q;
  assign vga.line_start_o  = line_start_q;
  assign vga.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for horizontal timing,
// a tiny-raster instance (16x12 totals) for vertical/frame timing and enable
// handling, and the same tiny raster with CLK_DIV=2 for the prescaler.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic en_def, en_sm, en_div;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(12)) vif_def ();
  vga_timing_gen_if #(.CW(12)) vif_sm ();
  vga_timing_gen_if #(.CW(12)) vif_div ();

  vga_timing_gen u_def (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_def), .vga(vif_def)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(1)
  ) u_sm (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_sm), .vga(vif_sm)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(2)
  ) u_div (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_div), .vga(vif_div)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  typedef struct {
    int k;   // edges since reset release
    int x, y, ha, va, bn, hs, vs, ls, fs;
  } vec_t;

  vec_t vt[12];

  initial begin
    int n, cnt, first_x, last_x, prev_vs, vs_first_x, vs_first_y, va_bad;
    int xbad, toggles, old_pce;
    bit found;

    rst_n  = 1'b0;
    en_def = 1'b1;
    en_sm  = 1'b1;
    en_div = 1'b1;

    vt[0]  = '{1,    0,   0, 1, 1, 1, 1, 1, 1, 1};
    vt[1]  = '{2,    1,   0, 1, 1, 1, 1, 1, 0, 0};
    vt[2]  = '{640,  639, 0, 1, 1, 1, 1, 1, 0, 0};
    vt[3]  = '{641,  640, 0, 0, 1, 0, 1, 1, 0, 0};
    vt[4]  = '{656,  655, 0, 0, 1, 0, 1, 1, 0, 0};
    vt[5]  = '{657,  656, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[6]  = '{752,  751, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[7]  = '{753,  752, 0, 0, 1, 0, 1, 1, 0, 0};
    vt[8]  = '{800,  799, 0, 0, 1, 0, 1, 1, 0, 0};
    vt[9]  = '{801,  0,   1, 1, 1, 1, 1, 1, 1, 0};
    vt[10] = '{802,  1,   1, 1, 1, 1, 1, 1, 0, 0};
    vt[11] = '{1601, 0,   2, 1, 1, 1, 1, 1, 1, 0};

    // Reset state (en high while reset held).
    step();
    step();
    chk("rst_x",   vif_def.x_o, 799);
    chk("rst_y",   vif_def.y_o, 524);
    chk("rst_ha",  vif_def.h_active, 0);
    chk("rst_va",  vif_def.v_active, 0);
    chk("rst_bn",  vif_def.blank_n, 0);
    chk("rst_hs",  vif_def.hs, 1);
    chk("rst_vs",  vif_def.vs, 1);
    chk("rst_ls",  vif_def.line_start_o, 0);
    chk("rst_fs",  vif_def.frame_start_o, 0);
    chk("rst_pce", vif_def.pix_ce_o, 0);
    chk("rst_sm_x", vif_sm.x_o, 15);
    chk("rst_sm_y", vif_sm.y_o, 11);
    chk("rst_div_x", vif_div.x_o, 15);

    // Release and walk the default raster through the vector table.
    rst_n = 1'b1;
    edge_cnt = 0;
    foreach (vt[i]) begin
      while (edge_cnt < vt[i].k) step();
      chk($sformatf("v%0d_x", i),  vif_def.x_o, vt[i].x);
      chk($sformatf("v%0d_y", i),  vif_def.y_o, vt[i].y);
      chk($sformatf("v%0d_ha", i), vif_def.h_active, vt[i].ha);
      chk($sformatf("v%0d_va", i), vif_def.v_active, vt[i].va);
      chk($sformatf("v%0d_bn", i), vif_def.blank_n, vt[i].bn);
      chk($sformatf("v%0d_hs", i), vif_def.hs, vt[i].hs);
      chk($sformatf("v%0d_vs", i), vif_def.vs, vt[i].vs);
      chk($sformatf("v%0d_ls", i), vif_def.line_start_o, vt[i].ls);
      chk($sformatf("v%0d_fs", i), vif_def.frame_start_o, vt[i].fs);
    end

    // hs width/position over one full line, and line period.
    found = 0;
    for (int j = 0; j < 900; j++) begin
      if (vif_def.line_start_o) begin found = 1; break; end
      step();
    end
    chk("def_ls_wait", found, 1);
    cnt = 0; first_x = -1; last_x = -1; n = 0;
    for (int j = 0; j < 800; j++) begin
      if (vif_def.hs == 1'b0) begin
        cnt++;
        if (first_x < 0) first_x = vif_def.x_o;
        last_x = vif_def.x_o;
      end
      if (j > 0 && vif_def.line_start_o) n++;
      step();
    end
    chk("hs_low_cnt", cnt, 96);
    chk("hs_first_x", first_x, 656);
    chk("hs_last_x",  last_x, 751);
    chk("ls_extra",   n, 0);
    chk("ls_period",  vif_def.line_start_o, 1);

    // Tiny raster: frame period, vs width/start, v_active in blanking.
    found = 0;
    for (int j = 0; j < 400; j++) begin
      if (vif_sm.frame_start_o) begin found = 1; break; end
      step();
    end
    chk("sm_fs_wait", found, 1);
    cnt = 0; prev_vs = vif_sm.vs; vs_first_x = -1; vs_first_y = -1; va_bad = 0; n = 0;
    for (int j = 1; j <= 400; j++) begin
      step();
      if (vif_sm.vs == 1'b0) cnt++;
      if (vif_sm.vs == 1'b0 && prev_vs == 1 && vs_first_x < 0) begin
        vs_first_x = vif_sm.x_o;
        vs_first_y = vif_sm.y_o;
      end
      prev_vs = vif_sm.vs;
      if (vif_sm.y_o >= 6 && vif_sm.v_active) va_bad++;
      if (vif_sm.frame_start_o) begin n = j; break; end
    end
    chk("sm_fs_period", n, 192);
    chk("sm_vs_cnt",    cnt, 32);
    chk("sm_vs_x0",     vs_first_x, 0);
    chk("sm_vs_y0",     vs_first_y, 8);
    chk("sm_va_blank",  va_bad, 0);

    // CLK_DIV=2: x holds two clocks, pix_ce toggles, line period 32.
    found = 0;
    for (int j = 0; j < 100; j++) begin
      if (vif_div.line_start_o) begin found = 1; break; end
      step();
    end
    chk("div_ls_wait", found, 1);
    xbad = 0; toggles = 0;
    for (int j = 0; j < 32; j++) begin
      if (vif_div.x_o != 12'(j / 2)) xbad++;
      old_pce = vif_div.pix_ce_o;
      step();
      if (vif_div.pix_ce_o != old_pce[0]) toggles++;
    end
    chk("div_x_hold",    xbad, 0);
    chk("div_pce_tog",   toggles, 32);
    chk("div_ls_period", vif_div.line_start_o, 1);
    found = 0;
    for (int j = 0; j < 500; j++) begin
      if (vif_div.frame_start_o) begin found = 1; break; end
      step();
    end
    chk("div_fs_wait", found, 1);
    step();
    chk("div_fs_width", vif_div.frame_start_o, 0);

    // Enable dropped mid-frame on the tiny raster.
    found = 0;
    for (int j = 0; j < 400; j++) begin
      if (vif_sm.x_o == 5 && vif_sm.y_o == 3) begin found = 1; break; end
      step();
    end
    chk("en_pos_wait", found, 1);
    en_sm = 1'b0;
    #1;
    chk("en_pce_low", vif_sm.pix_ce_o, 0);
    step();
    chk("en_x",  vif_sm.x_o, 15);
    chk("en_y",  vif_sm.y_o, 11);
    chk("en_bn", vif_sm.blank_n, 0);
    chk("en_hs", vif_sm.hs, 1);
    chk("en_vs", vif_sm.vs, 1);
    chk("en_ls", vif_sm.line_start_o, 0);
    repeat (4) step();
    chk("en_hold_x", vif_sm.x_o, 15);
    chk("en_hold_y", vif_sm.y_o, 11);
    en_sm = 1'b1;
    step();
    chk("en_re_x",  vif_sm.x_o, 0);
    chk("en_re_y",  vif_sm.y_o, 0);
    chk("en_re_fs", vif_sm.frame_start_o, 1);
    chk("en_re_ls", vif_sm.line_start_o, 1);
    chk("en_re_bn", vif_sm.blank_n, 1);

    // Asynchronous reset pulse between edges.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_x",   vif_def.x_o, 799);
    chk("ar_y",   vif_def.y_o, 524);
    chk("ar_bn",  vif_def.blank_n, 0);
    chk("ar_hs",  vif_def.hs, 1);
    chk("ar_vs",  vif_def.vs, 1);
    chk("ar_ls",  vif_def.line_start_o, 0);
    chk("ar_fs",  vif_def.frame_start_o, 0);
    chk("ar_pce", vif_def.pix_ce_o, 0);
    chk("ar_sm_x", vif_sm.x_o, 15);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rs_x",  vif_def.x_o, 0);
    chk("rs_y",  vif_def.y_o, 0);
    chk("rs_fs", vif_def.frame_start_o, 1);
    chk("rs_ls", vif_def.line_start_o, 1);
    chk("rs_bn", vif_def.blank_n, 1);
    step();
    chk("rs_fs_off", vif_def.frame_start_o, 0);
    chk("rs_x1",     vif_def.x_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
